// File: rtl/pc_bpred.sv
// pc_bpred -- fetch PC generator with a direct-mapped BTB and 2-bit
// saturating direction counters.
//
// Ports:
//   clk_in            rising-edge clock
//   rst_in            asynchronous active-high reset
//   rdy_in            global ready; low freezes PC and BTB
//   stall_in          stall vector; only bit 0 (PC stage) is used
//   ex_valid          EX resolved a branch/jump (trains the BTB)
//   ex_pc/ex_taken/ex_target   resolved branch info
//   ex_mispredict     redirect fetch to ex_redirect_addr (beats stall)
//   pc_out            registered fetch PC
//   pred_taken_out    BTB prediction for pc_out (combinational)
//   pred_target_out   predicted next PC for pc_out (combinational)
//
// Optional feature macro: BPRED_STATS_EN adds stat_branch_cnt and
// stat_mispred_cnt (saturating 32-bit event counters).
module pc_bpred #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    BTB_INDEX_LEN = 4,
  parameter int                    STALL_WIDTH   = 6,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic [STALL_WIDTH-1:0] stall_in,
  input  logic                   ex_valid,
  input  logic [ADDR_WIDTH-1:0]  ex_pc,
  input  logic                   ex_taken,
  input  logic [ADDR_WIDTH-1:0]  ex_target,
  input  logic                   ex_mispredict,
  input  logic [ADDR_WIDTH-1:0]  ex_redirect_addr,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic                   pred_taken_out,
  output logic [ADDR_WIDTH-1:0]  pred_target_out
`ifdef BPRED_STATS_EN
  ,
  output logic [31:0]            stat_branch_cnt,
  output logic [31:0]            stat_mispred_cnt
`endif
);

  localparam int NENT  = 1 << BTB_INDEX_LEN;
  localparam int TAG_W = ADDR_WIDTH - BTB_INDEX_LEN - 2;

  logic [ADDR_WIDTH-1:0]            r_pc;
  logic [NENT-1:0]                  r_valid;
  logic [NENT-1:0][TAG_W-1:0]       r_tag;
  logic [NENT-1:0][ADDR_WIDTH-1:0]  r_target;
  logic [NENT-1:0][1:0]             r_ctr;

  logic [BTB_INDEX_LEN-1:0] w_idx, w_ex_idx;
  logic [TAG_W-1:0]         w_tag, w_ex_tag;
  logic                     w_hit, w_ex_hit;
  logic [ADDR_WIDTH-1:0]    w_pc_next;

  // Instruction-alignment bits of ex_pc and the upper stall bits are
  // intentionally ignored.
  logic w_unused;
  assign w_unused = &{1'b0, stall_in, ex_pc[1:0]};

  // Lookup on the current fetch PC; reads pre-write contents.
  assign w_idx           = r_pc[BTB_INDEX_LEN+1:2];
  assign w_tag           = r_pc[ADDR_WIDTH-1:BTB_INDEX_LEN+2];
  assign w_hit           = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign pred_taken_out  = w_hit && r_ctr[w_idx][1];
  assign pred_target_out = pred_taken_out ? r_target[w_idx]
                                          : r_pc + ADDR_WIDTH'(4);
  assign pc_out          = r_pc;

  // Training-side lookup on the resolved branch PC.
  assign w_ex_idx = ex_pc[BTB_INDEX_LEN+1:2];
  assign w_ex_tag = ex_pc[ADDR_WIDTH-1:BTB_INDEX_LEN+2];
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  // Redirect wins over the PC-stage stall.
  always_comb begin
    w_pc_next = r_pc;
    if (ex_mispredict)  w_pc_next = ex_redirect_addr;
    else if (!stall_in[0]) w_pc_next = pred_target_out;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      r_pc <= RESET_PC;
    else if (rdy_in) r_pc <= w_pc_next;
  end

  // BTB: counters reset to weakly-not-taken so a fresh allocation (10)
  // predicts taken while a single not-taken drops it back.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NENT; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (rdy_in && ex_valid) begin
      if (w_ex_hit) begin
        if (ex_taken) begin
          r_target[w_ex_idx] <= ex_target;
          if (r_ctr[w_ex_idx] != 2'b11) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
        end else if (r_ctr[w_ex_idx] != 2'b00) begin
          r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
        end
      end else if (ex_taken) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= ex_target;
        r_ctr[w_ex_idx]    <= 2'b10;
      end
    end
  end

`ifdef BPRED_STATS_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stat_branch_cnt  <= '0;
      stat_mispred_cnt <= '0;
    end else if (rdy_in) begin
      if (ex_valid && stat_branch_cnt != 32'hFFFF_FFFF)
        stat_branch_cnt <= stat_branch_cnt + 32'd1;
      if (ex_mispredict && stat_mispred_cnt != 32'hFFFF_FFFF)
        stat_mispred_cnt <= stat_mispred_cnt + 32'd1;
    end
  end
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_pc_bpred.sv
module tb_pc_bpred;
  localparam int NENT = 16;

  logic        clk_in = 0;
  logic        rst_in, rdy_in, ex_valid, ex_taken, ex_mispredict;
  logic [5:0]  stall_in;
  logic [31:0] ex_pc, ex_target, ex_redirect_addr;
  logic [31:0] pc_out, pred_target_out;
  logic        pred_taken_out;
`ifdef BPRED_STATS_EN
  logic [31:0] stat_branch_cnt, stat_mispred_cnt;
`endif

  pc_bpred dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall_in(stall_in),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_mispredict(ex_mispredict),
    .ex_redirect_addr(ex_redirect_addr), .pc_out(pc_out),
    .pred_taken_out(pred_taken_out), .pred_target_out(pred_target_out)
`ifdef BPRED_STATS_EN
    , .stat_branch_cnt(stat_branch_cnt), .stat_mispred_cnt(stat_mispred_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic rdy; logic [5:0] stall; logic exv; logic [31:0] expc; logic extk;
    logic [31:0] extgt; logic mis; logic [31:0] maddr;
    logic [31:0] e_pc; logic e_tk; logic [31:0] e_tgt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rdy, logic [5:0] stall, logic exv, logic [31:0] expc,
                              logic extk, logic [31:0] extgt, logic mis, logic [31:0] maddr,
                              logic [31:0] e_pc, logic e_tk, logic [31:0] e_tgt);
    vec_t v;
    v.rdy = rdy; v.stall = stall; v.exv = exv; v.expc = expc; v.extk = extk;
    v.extgt = extgt; v.mis = mis; v.maddr = maddr;
    v.e_pc = e_pc; v.e_tk = e_tk; v.e_tgt = e_tgt;
    return v;
  endfunction

  task automatic drive(input logic rdy, input logic [5:0] stall, input logic exv,
                       input logic [31:0] expc, input logic extk, input logic [31:0] extgt,
                       input logic mis, input logic [31:0] maddr);
    rdy_in = rdy; stall_in = stall; ex_valid = exv; ex_pc = expc; ex_taken = extk;
    ex_target = extgt; ex_mispredict = mis; ex_redirect_addr = maddr;
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_out(input string nm, input logic [31:0] p, input logic t, input logic [31:0] g);
    chk({nm, ".pc"}, pc_out, p);
    chk({nm, ".taken"}, {31'd0, pred_taken_out}, {31'd0, t});
    chk({nm, ".target"}, pred_target_out, g);
  endtask

  // Reference model: BTB as plain arrays, index/tag by division.
  logic [31:0] m_pc;
  bit          m_v[NENT];
  logic [31:0] m_tag[NENT], m_tgt[NENT];
  int          m_ctr[NENT];
  longint      m_br, m_mp;

  function automatic int midx(logic [31:0] a); return int'((a / 4) % NENT); endfunction
  function automatic logic [31:0] mtagof(logic [31:0] a); return a / (4 * NENT); endfunction
  function automatic bit m_taken(logic [31:0] a);
    int i = midx(a);
    return m_v[i] && m_tag[i] == mtagof(a) && m_ctr[i] >= 2;
  endfunction
  function automatic logic [31:0] m_pred(logic [31:0] a);
    return m_taken(a) ? m_tgt[midx(a)] : a + 32'd4;
  endfunction

  task automatic m_reset();
    m_pc = 0; m_br = 0; m_mp = 0;
    for (int i = 0; i < NENT; i++) begin m_v[i] = 0; m_ctr[i] = 1; m_tag[i] = 0; m_tgt[i] = 0; end
  endtask

  task automatic m_step();
    logic [31:0] np;
    int i;
    if (!rdy_in) return;
    np = m_pc;
    if (ex_mispredict) np = ex_redirect_addr;
    else if (!stall_in[0]) np = m_pred(m_pc);
    if (ex_valid) begin
      m_br++;
      i = midx(ex_pc);
      if (m_v[i] && m_tag[i] == mtagof(ex_pc)) begin
        if (ex_taken) begin m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3; m_tgt[i] = ex_target; end
        else m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end else if (ex_taken) begin
        m_v[i] = 1; m_tag[i] = mtagof(ex_pc); m_tgt[i] = ex_target; m_ctr[i] = 2;
      end
    end
    if (ex_mispredict) m_mp++;
    m_pc = np;
  endtask

  initial begin
    // Directed vectors from reset (pc=0, BTB empty); expected = outputs after the edge.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0, 32'h8));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h8, 0, 32'hC));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'hC, 0, 32'h10));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h10, 0, 32'h14));
    tbl.push_back(mk(1, 6'b000001, 0, 0, 0, 0, 0, 0, 32'h10, 0, 32'h14));
    tbl.push_back(mk(1, 6'b000001, 0, 0, 0, 0, 0, 0, 32'h10, 0, 32'h14));
    tbl.push_back(mk(1, 6'b000001, 0, 0, 0, 0, 0, 0, 32'h10, 0, 32'h14));
    tbl.push_back(mk(1, 6'b000010, 0, 0, 0, 0, 0, 0, 32'h14, 0, 32'h18));
    tbl.push_back(mk(0, 0, 1, 32'h14, 1, 32'h400, 1, 32'h300, 32'h14, 0, 32'h18));
    tbl.push_back(mk(1, 6'b000001, 0, 0, 0, 0, 1, 32'h100, 32'h100, 0, 32'h104));
    tbl.push_back(mk(1, 0, 1, 32'h20, 1, 32'h80, 1, 32'h20, 32'h20, 1, 32'h80));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h80, 0, 32'h84));
    tbl.push_back(mk(1, 0, 1, 32'h20, 0, 0, 1, 32'h20, 32'h20, 0, 32'h24));
    tbl.push_back(mk(1, 6'b000001, 1, 32'h20, 0, 0, 0, 0, 32'h20, 0, 32'h24));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h24, 0, 32'h28));
    tbl.push_back(mk(1, 0, 1, 32'h20, 1, 32'h80, 1, 32'h20, 32'h20, 0, 32'h24));
    tbl.push_back(mk(1, 6'b000001, 1, 32'h20, 1, 32'h90, 0, 0, 32'h20, 1, 32'h90));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h90, 0, 32'h94));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h60, 32'h60, 0, 32'h64));
    tbl.push_back(mk(1, 6'b000001, 1, 32'h60, 1, 32'h200, 0, 0, 32'h60, 1, 32'h200));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h20, 32'h20, 0, 32'h24));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h4));

    rst_in = 1; idle();
    #12;
    chk_out("reset", 32'h0, 0, 32'h4);
    @(posedge clk_in); #1 rst_in = 0;
    chk_out("release", 32'h0, 0, 32'h4);

    foreach (tbl[k]) begin
      drive(tbl[k].rdy, tbl[k].stall, tbl[k].exv, tbl[k].expc, tbl[k].extk,
            tbl[k].extgt, tbl[k].mis, tbl[k].maddr);
      @(posedge clk_in); #1;
      chk_out($sformatf("vec%0d", k), tbl[k].e_pc, tbl[k].e_tk, tbl[k].e_tgt);
    end

    // Same-cycle lookup and train at one index: old contents until the edge.
    drive(1, 0, 0, 0, 0, 0, 1, 32'h40);
    @(posedge clk_in); #1;
    drive(1, 6'b000001, 1, 32'h40, 1, 32'h500, 0, 0);
    #1 chk_out("same_cyc.before", 32'h40, 0, 32'h44);
    @(posedge clk_in); #1;
    chk_out("same_cyc.after", 32'h40, 1, 32'h500);
    idle();

    // Asynchronous reset mid-run, away from any clock edge.
    @(posedge clk_in); #3 rst_in = 1;
    #1 chk_out("async_rst", 32'h0, 0, 32'h4);
    @(posedge clk_in); #1 rst_in = 0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk_in); #1;
      chk_out($sformatf("rst_seq%0d", k), 32'(4 * k), 0, 32'(4 * k + 4));
    end

    // Randomized run against the model.
    #2 rst_in = 1; #2 rst_in = 0;
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc_r, tg_r, ma_r;
      pc_r = ($urandom_range(0, 3) == 0) ? {$urandom_range(0, 63), 2'b00} : m_pc;
      tg_r = {$urandom_range(0, 63), 2'b00};
      ma_r = {$urandom_range(0, 63), 2'b00};
      drive($urandom_range(0, 9) != 0, 6'($urandom), $urandom_range(0, 1),
            pc_r, $urandom_range(0, 1), tg_r, $urandom_range(0, 3) == 0, ma_r);
      m_step();
      @(posedge clk_in); #1;
      chk_out($sformatf("rnd%0d", n), m_pc, m_taken(m_pc), m_pred(m_pc));
    end
`ifdef BPRED_STATS_EN
    chk("stat_branch", stat_branch_cnt, 32'(m_br));
    chk("stat_mispred", stat_mispred_cnt, 32'(m_mp));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_bpred.md
Name: pc_bpred

Overview:
Parametrised program-counter generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It replaces the fixed +4/redirect PC and feeds instruction fetch. Each cycle it predicts the next fetch address from the current PC. EX trains the BTB with resolved branches and redirects fetch on a mispredict.

Parameters:
ADDR_WIDTH, 32, PC/target width in bits.
BTB_INDEX_LEN, 4, log2 of BTB entry count (default 16 entries).
STALL_WIDTH, 6, width of the stall-control vector. Bit 0 stalls the PC stage.
RESET_PC, 0, PC value while reset is asserted and on release.

Ports:
clk_in  input  1  clock, rising edge.
rst_in  input  1  reset, asynchronous, active-high.
rdy_in  input  1  global ready. Low freezes all state.
stall_in  input  STALL_WIDTH  stall vector from stall control. Bit 0 holds the PC.
ex_valid  input  1  EX resolved a branch/jump this cycle.
ex_pc  input  ADDR_WIDTH  PC of the resolved branch.
ex_taken  input  1  resolved direction.
ex_target  input  ADDR_WIDTH  resolved taken target.
ex_mispredict  input  1  redirect request.
ex_redirect_addr  input  ADDR_WIDTH  correct next PC on redirect.
pc_out  output  ADDR_WIDTH  current fetch PC (registered).
pred_taken_out  output  1  prediction for pc_out (combinational from BTB). Carried down the pipe.
pred_target_out  output  ADDR_WIDTH  predicted next PC for pc_out (combinational).

Behaviour:
- BTB entry fields: valid, tag = pc[ADDR_WIDTH-1:BTB_INDEX_LEN+2], target[ADDR_WIDTH-1:0], ctr[1:0].
- Index: pc[BTB_INDEX_LEN+1:2].
- Lookup on pc_out:
  - hit = valid && tag match.
  - pred_taken_out = hit && ctr[1].
  - pred_target_out = pred_taken_out ? target : pc_out+4.
  - pc_out+4 wraps modulo 2^ADDR_WIDTH.
- Reset (async, any time including mid-redirect):
  - pc_out = RESET_PC.
  - All valid = 0, all ctr = 2'b01.
  - Hence pred_taken_out = 0 and pred_target_out = RESET_PC+4.
- PC update at posedge, first match wins:
  1. rdy_in = 0: hold everything. BTB is not written, even if ex_valid or ex_mispredict is set.
  2. ex_mispredict = 1: pc_out <= ex_redirect_addr. This overrides stall_in[0].
  3. stall_in[0] = 1: hold pc_out. Other stall bits are ignored.
  4. Otherwise: pc_out <= pred_target_out.
- BTB training on (rdy_in && ex_valid), independent of stall and redirect:
  - Tag hit at ex_pc index:
    - ex_taken: ctr saturating-increments (max 2'b11) and target <= ex_target.
    - Not taken: ctr saturating-decrements (min 2'b00). Target is unchanged.
  - Miss and ex_taken: allocate/replace. valid=1, tag from ex_pc, target=ex_target, ctr=2'b10.
  - Miss and not taken: no write.
- Same-cycle lookup and train at the same index: lookup uses old contents. The write is visible the next cycle.
- Target low bits are stored as given. No alignment is enforced.
- Latency: one cycle from an EX event to the pc_out change or BTB visibility.

Optional Feature:
BPRED_STATS_EN
- Defined: adds two outputs, stat_branch_cnt (32) and stat_mispred_cnt (32).
  - stat_branch_cnt counts rdy_in && ex_valid cycles.
  - stat_mispred_cnt counts rdy_in && ex_mispredict cycles.
  - Both reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: both ports and counters are absent. All other behaviour is identical.

Test Plan:
- Sequencing: assert rst_in mid-run, asynchronously → pc_out = 0 immediately. Release with rdy=1, stall=0 → pc_out 0,4,8,0xC.
- Stall and ready: stall_in=6'b000001 for 3 cycles at pc 0x10 → pc_out holds 0x10. stall_in=6'b000010 → advances to 0x14. rdy_in=0 with ex_mispredict=1 → no change.
- Redirect priority: ex_mispredict=1, addr 0x100, with stall_in[0]=1 → pc_out = 0x100 next cycle.
- Learning:
  - ex_valid, ex_taken, ex_pc=0x20, ex_target=0x80 → entry allocated with ctr=10.
  - When pc_out=0x20: pred_taken_out=1 and the next pc_out = 0x80.
- Hysteresis:
  - Two not-taken trains at 0x20 → ctr=00. Fetch then gives 0x20→0x24.
  - One taken train → ctr=01, still not predicted.
  - A second taken train → ctr=10, predicted.
- Aliasing: 0x20 and 0x60 share index 8 with different tags.
  - pc_out=0x60 → no hit.
  - A taken train at 0x60 (target 0x200) replaces the entry. 0x20 then misses.
